// File: rtl/elevator_call_register_if.sv
// Button/controller bundle for the elevator call register.
// The master drives the raw buttons and controller status; the slave returns pending requests.
interface elevator_call_register_if;
    logic [2:0] press_up;
    logic [2:0] press_down;
    logic [3:0] press_in;
    logic [2:0] position;
    logic       open;
    logic [1:0] direction;
    logic [2:0] req_up;
    logic [2:0] req_down;
    logic [3:0] req_in;
    logic [3:0] pending_count;
    logic       pending_any;

    modport master (
        output press_up, press_down, press_in, position, open, direction,
        input  req_up, req_down, req_in, pending_count, pending_any
    );

    modport slave (
        input  press_up, press_down, press_in, position, open, direction,
        output req_up, req_down, req_in, pending_count, pending_any
    );
endinterface

// File: rtl/elevator_call_register.sv
// Captures hall/car button presses as one-shot pending requests and clears them when served.
// All outputs are registered; there is no combinational path from buttons to outputs.
module elevator_call_register #(
    parameter bit CLEAR_ON_STOP = 1'b1
) (
    input logic                     clk,
    input logic                     reset,
    elevator_call_register_if.slave bus
);

    logic [2:0] up_q, dn_q;
    logic [3:0] in_q;
    logic [2:0] req_up_q, req_up_d;
    logic [2:0] req_dn_q, req_dn_d;
    logic [3:0] req_in_q, req_in_d;
    logic [3:0] count_q, count_d;
    logic       any_q;

    logic [2:0] edge_up, edge_dn, clr_up, clr_dn;
    logic [3:0] edge_in, clr_in;
    logic       at_floor, stop_ok, dir_up, dir_dn;
    logic [1:0] floor;

    always_comb begin
        edge_up  = bus.press_up & ~up_q;
        edge_dn  = bus.press_down & ~dn_q;
        edge_in  = bus.press_in & ~in_q;
        at_floor = ~bus.position[0] & bus.open;
        floor    = bus.position[2:1];
        stop_ok  = (bus.direction == 2'b00) && CLEAR_ON_STOP;
        dir_up   = (bus.direction == 2'b01) || stop_ok;
        dir_dn   = (bus.direction == 2'b10) || stop_ok;

        clr_up = '0;
        clr_dn = '0;
        clr_in = '0;
        for (int i = 0; i < 4; i++) begin
            clr_in[i] = at_floor && (floor == 2'(i));
        end
        // Down call index i belongs to floor i+1 (2nd..4th floor).
        for (int i = 0; i < 3; i++) begin
            clr_up[i] = at_floor && dir_up && (floor == 2'(i));
            clr_dn[i] = at_floor && dir_dn && (floor == 2'(i + 1));
        end

        req_up_d = (req_up_q | edge_up) & ~clr_up;
        req_dn_d = (req_dn_q | edge_dn) & ~clr_dn;
        req_in_d = (req_in_q | edge_in) & ~clr_in;

        count_d = '0;
        for (int i = 0; i < 3; i++) begin
            count_d = count_d + {3'b000, req_up_d[i]} + {3'b000, req_dn_d[i]};
        end
        for (int i = 0; i < 4; i++) begin
            count_d = count_d + {3'b000, req_in_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        // Prior samples track the buttons even in reset so a held button never fires on release.
        up_q <= bus.press_up;
        dn_q <= bus.press_down;
        in_q <= bus.press_in;
        if (reset) begin
            req_up_q <= '0;
            req_dn_q <= '0;
            req_in_q <= '0;
            count_q  <= '0;
            any_q    <= 1'b0;
        end else begin
            req_up_q <= req_up_d;
            req_dn_q <= req_dn_d;
            req_in_q <= req_in_d;
            count_q  <= count_d;
            any_q    <= (count_d != 4'd0);
        end
    end

    assign bus.req_up        = req_up_q;
    assign bus.req_down      = req_dn_q;
    assign bus.req_in        = req_in_q;
    assign bus.pending_count = count_q;
    assign bus.pending_any   = any_q;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed bench for elevator_call_register; a second instance covers CLEAR_ON_STOP=0.
module tb_elevator_call_register;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    elevator_call_register_if bus ();
    elevator_call_register_if bus0 ();

    assign bus0.press_up   = bus.press_up;
    assign bus0.press_down = bus.press_down;
    assign bus0.press_in   = bus.press_in;
    assign bus0.position   = bus.position;
    assign bus0.open       = bus.open;
    assign bus0.direction  = bus.direction;

    elevator_call_register #(.CLEAR_ON_STOP(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    elevator_call_register #(.CLEAR_ON_STOP(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_pos();
        bus.position  = 3'b001;
        bus.open      = 1'b0;
        bus.direction = 2'b00;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.press_up   = 3'b000;
        bus.press_down = 3'b000;
        bus.press_in   = 4'b0001;
        idle_pos();

        // Button held through reset must not create a request.
        tick();
        tick();
        chk("rst_req_up", 32'(bus.req_up), 32'h0);
        chk("rst_req_down", 32'(bus.req_down), 32'h0);
        chk("rst_req_in", 32'(bus.req_in), 32'h0);
        chk("rst_count", 32'(bus.pending_count), 32'h0);
        chk("rst_any", 32'(bus.pending_any), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_req_in", 32'(bus.req_in), 32'h0);
            chk("held_count", 32'(bus.pending_count), 32'h0);
        end
        bus.press_in = 4'b0000;
        tick();
        bus.press_in = 4'b0001;
        tick();
        chk("repress_req_in", 32'(bus.req_in), 32'h1);
        chk("repress_count", 32'(bus.pending_count), 32'h1);
        chk("repress_any", 32'(bus.pending_any), 32'h1);

        // Serve the car call at floor 1.
        bus.press_in = 4'b0000;
        bus.position = 3'b000;
        bus.open     = 1'b1;
        tick();
        chk("car_clr_req_in", 32'(bus.req_in), 32'h0);
        chk("car_clr_count", 32'(bus.pending_count), 32'h0);
        idle_pos();

        // Held hall-up button: one edge only.
        bus.press_up = 3'b010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_up_req", 32'(bus.req_up), 32'h2);
            chk("held_up_count", 32'(bus.pending_count), 32'h1);
        end
        bus.press_up = 3'b000;

        // Directional clear at floor 2.
        bus.press_down = 3'b001;
        tick();
        bus.press_down = 3'b000;
        chk("dir_setup_down", 32'(bus.req_down), 32'h1);
        chk("dir_setup_count", 32'(bus.pending_count), 32'h2);
        bus.position  = 3'b010;
        bus.open      = 1'b1;
        bus.direction = 2'b01;
        tick();
        chk("dir_up_req_up", 32'(bus.req_up), 32'h0);
        chk("dir_up_req_down", 32'(bus.req_down), 32'h1);
        chk("dir_up_count", 32'(bus.pending_count), 32'h1);
        bus.direction = 2'b10;
        tick();
        chk("dir_dn_req_down", 32'(bus.req_down), 32'h0);
        chk("dir_dn_count", 32'(bus.pending_count), 32'h0);
        chk("dir_dn_any", 32'(bus.pending_any), 32'h0);
        idle_pos();

        // Stop clears both hall calls only when CLEAR_ON_STOP=1.
        bus.press_up   = 3'b010;
        bus.press_down = 3'b001;
        tick();
        bus.press_up   = 3'b000;
        bus.press_down = 3'b000;
        chk("stop_setup_count", 32'(bus.pending_count), 32'h2);
        chk("stop_setup_count0", 32'(bus0.pending_count), 32'h2);
        bus.position = 3'b010;
        bus.open     = 1'b1;
        tick();
        chk("stop1_req_up", 32'(bus.req_up), 32'h0);
        chk("stop1_req_down", 32'(bus.req_down), 32'h0);
        chk("stop1_count", 32'(bus.pending_count), 32'h0);
        chk("stop0_req_up", 32'(bus0.req_up), 32'h2);
        chk("stop0_req_down", 32'(bus0.req_down), 32'h1);
        chk("stop0_count", 32'(bus0.pending_count), 32'h2);

        // Invalid direction: hall calls kept, car call press at this floor absorbed.
        bus.direction = 2'b11;
        bus.press_in  = 4'b0010;
        tick();
        bus.press_in = 4'b0000;
        chk("dir11_hall_count0", 32'(bus0.pending_count), 32'h2);
        chk("dir11_req_in", 32'(bus.req_in), 32'h0);
        idle_pos();
        tick();

        // Press coinciding with clear is absorbed; between floors it is not.
        bus.press_in = 4'b0100;
        bus.position = 3'b100;
        bus.open     = 1'b1;
        tick();
        chk("absorb_req_in", 32'(bus.req_in), 32'h0);
        bus.press_in = 4'b0000;
        tick();
        bus.press_in = 4'b0100;
        bus.position = 3'b101;
        tick();
        chk("between_req_in", 32'(bus.req_in), 32'h4);
        chk("between_count", 32'(bus.pending_count), 32'h1);
        idle_pos();

        // All ten buttons at once, then reset.
        bus.press_up   = 3'b111;
        bus.press_down = 3'b111;
        bus.press_in   = 4'b1111;
        tick();
        chk("full_count", 32'(bus.pending_count), 32'd10);
        chk("full_any", 32'(bus.pending_any), 32'h1);
        chk("full_req_up", 32'(bus.req_up), 32'h7);
        chk("full_req_down", 32'(bus.req_down), 32'h7);
        chk("full_req_in", 32'(bus.req_in), 32'hf);
        chk("full_count0", 32'(bus0.pending_count), 32'd10);
        reset = 1'b1;
        tick();
        chk("mid_rst_count", 32'(bus.pending_count), 32'h0);
        chk("mid_rst_any", 32'(bus.pending_any), 32'h0);
        chk("mid_rst_req_in", 32'(bus.req_in), 32'h0);
        chk("mid_rst_req_up", 32'(bus.req_up), 32'h0);
        chk("mid_rst_count0", 32'(bus0.pending_count), 32'h0);
        reset = 1'b0;
        tick();
        chk("post_rst_held_count", 32'(bus.pending_count), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
